mul_dispatch: RTL and testbench

//  Upstream feeder for the 16x16 start/busy multiplier: buffers operand pairs from a valid/ready source,

---
 rtl/mul_pkg.sv | 24 ++
 rtl/mul_op_fifo.sv | 63 ++++++
 rtl/mul_dispatch.sv | 152 +++++++++++++++
 tb/tb_mul_dispatch.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the 16x16 start/busy multiplier and its dispatcher.
// Also imported by the multiplier testbench.
package mul_pkg;

    localparam int DATA_W = 16;
    localparam int PROD_W = 32;

    // Dispatcher sequencing states
    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        ARM,
        RUN,
        CAPT,
        HOLD
    } mul_state_t;

    // One buffered operand pair
    typedef struct packed {
        logic [DATA_W-1:0] x;
        logic [DATA_W-1:0] y;
    } mul_op_t;

endpackage

// File: rtl/mul_op_fifo.sv
// Operand-pair FIFO for mul_dispatch: DEPTH entries of {x,y}, synchronous
// push/pop, show-ahead read port. A push is accepted while full if a pop
// happens in the same cycle (count stays the same).
module mul_op_fifo
    import mul_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  logic    pop,
    input  mul_op_t wdata,
    output mul_op_t rdata,
    output logic    full,
    output logic    empty
);

    localparam int                PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]    FULL_CNT = (PTR_W + 1)'(DEPTH);

    mul_op_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage write.
    // NOTE: the data array has no reset; entries are only read after being
    // written, and leaving it unreset lets it map onto plain RAM/flops.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mul_dispatch.sv
// mul_dispatch: streams operand pairs into a non-streaming start/busy
// multiplier. Buffers pairs, issues one start pulse per pair, waits for busy
// (with an arm timeout and a watchdog), captures the product and holds it on
// a valid/ready result port.
// Optional feature: define MUL_DISPATCH_ACC_EN to accumulate products into a
// wrapping 32-bit sum; an all-zero operand pair clears the sum.
module mul_dispatch
    import mul_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int ARM_CYC = 4,
    parameter int MAX_CYC = 40
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_y,
    output logic              mul_start,
    output logic [DATA_W-1:0] mul_x,
    output logic [DATA_W-1:0] mul_y,
    input  logic              mul_busy,
    input  logic [PROD_W-1:0] mul_z,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] out_z,
    output logic              err
);

    localparam int               CNT_W    = $clog2((MAX_CYC > ARM_CYC) ? MAX_CYC : ARM_CYC) + 1;
    localparam logic [CNT_W-1:0] ARM_LAST = CNT_W'(ARM_CYC - 1);
    localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_CYC - 1);

    mul_state_t        state;
    logic [CNT_W-1:0]  cnt;
    mul_op_t           head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_push;
    logic              fifo_pop;
    logic              accept;
    logic [PROD_W-1:0] cap_z;

    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && in_ready;
    assign accept    = (state == HOLD) && out_ready;
    // Pop whenever the FSM is about to issue: from IDLE, or straight out of
    // HOLD on result accept so back-to-back ops have no bubble.
    assign fifo_pop  = !fifo_empty && ((state == IDLE) || accept);

    mul_op_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ('{x: in_x, y: in_y}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef MUL_DISPATCH_ACC_EN
    logic [PROD_W-1:0] acc;

    // An all-zero operand pair is a clear token: its result and the new sum are 0.
    assign cap_z = ((mul_x == '0) && (mul_y == '0)) ? '0 : acc + mul_z;

    // Running sum, advanced only when a product is actually captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (state == CAPT) begin
            acc <= cap_z;
        end
    end
`else
    assign cap_z = mul_z;
`endif

    // Sequencer: issue, wait for busy/arm timeout/watchdog, capture, hold result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            mul_start <= 1'b0;
            mul_x     <= '0;
            mul_y     <= '0;
            out_valid <= 1'b0;
            out_z     <= '0;
            err       <= 1'b0;
        end else begin
            mul_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (fifo_pop) begin
                        mul_x     <= head.x;
                        mul_y     <= head.y;
                        mul_start <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= ARM;
                end
                ARM: begin
                    if (mul_busy) begin
                        cnt   <= '0;
                        state <= RUN;
                    end else if (cnt == ARM_LAST) begin
                        state <= CAPT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (!mul_busy) begin
                        state <= CAPT;
                    end else if (cnt == MAX_LAST) begin
                        err   <= 1'b1;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                CAPT: begin
                    out_z     <= cap_z;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (fifo_pop) begin
                            mul_x     <= head.x;
                            mul_y     <= head.y;
                            mul_start <= 1'b1;
                            state     <= ISSUE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_dispatch.sv
// Self-checking bench for mul_dispatch: behavioural start/busy multiplier,
// queue-based reference of issued operands and expected results.
module tb_mul_dispatch;

    localparam int DEPTH   = 4;
    localparam int ARM_CYC = 4;
    localparam int MAX_CYC = 40;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_x;
    logic [15:0] in_y;
    logic        mul_start;
    logic [15:0] mul_x;
    logic [15:0] mul_y;
    logic        mul_busy;
    logic [31:0] mul_z;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_z;
    logic        err;

    always #5 clk = ~clk;

    mul_dispatch #(
        .DEPTH   (DEPTH),
        .ARM_CYC (ARM_CYC),
        .MAX_CYC (MAX_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .in_y      (in_y),
        .mul_start (mul_start),
        .mul_x     (mul_x),
        .mul_y     (mul_y),
        .mul_busy  (mul_busy),
        .mul_z     (mul_z),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_z     (out_z),
        .err       (err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural multiplier ----------------
    logic        comb_mode  = 1'b0;  // busy never rises, z = x*y combinationally
    logic        stuck_mode = 1'b0;  // busy forced high
    int          lat_sel    = 16;    // busy length; 0 = random 1..12
    logic        busy_q;
    int          busy_cnt;
    logic [31:0] z_q;
    logic [15:0] px, py;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            busy_cnt <= 0;
            z_q      <= '0;
            px       <= '0;
            py       <= '0;
        end else if (mul_start && !comb_mode) begin
            busy_q   <= 1'b1;
            busy_cnt <= (lat_sel > 0) ? lat_sel : int'($urandom_range(1, 12));
            z_q      <= 32'hDEAD_BEEF;
            px       <= mul_x;
            py       <= mul_y;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) begin
                busy_q <= 1'b0;
                z_q    <= {16'b0, px} * {16'b0, py};
            end
        end
    end

    assign mul_busy = stuck_mode | busy_q;
    assign mul_z    = comb_mode ? ({16'b0, mul_x} * {16'b0, mul_y}) : z_q;

    // ---------------- reference model ----------------
    logic [31:0] issue_q[$];  // {x,y} in push order, checked at each start
    logic [31:0] exp_q[$];    // expected out_z for each non-aborted op
    logic [31:0] acc_m = '0;

    function automatic logic [31:0] model_result(input logic [15:0] x, input logic [15:0] y);
`ifdef MUL_DISPATCH_ACC_EN
        if (x == 16'd0 && y == 16'd0) acc_m = '0;
        else                          acc_m = acc_m + ({16'b0, x} * {16'b0, y});
        return acc_m;
`else
        return {16'b0, x} * {16'b0, y};
`endif
    endfunction

    // ---------------- monitor (samples on negedge) ----------------
    int          cycle = 0;
    int          start_cnt = 0;
    int          result_cnt = 0;
    int          last_start_cyc = 0;
    int          last_lat = 0;
    logic [31:0] last_z = '0;
    logic        seen_not_ready = 1'b0;
    logic        prev_start = 1'b0;
    logic        prev_valid = 1'b0;
    logic        prev_acc = 1'b0;
    logic [31:0] prev_z = '0;

    always @(negedge clk) begin
        cycle++;
        if (rst_n) begin
            if (!in_ready) seen_not_ready = 1'b1;
            if (mul_start) begin
                check("start_pulse_len", {31'b0, prev_start}, 32'd0);
                check("start_expected", {31'b0, issue_q.size() != 0}, 32'd1);
                if (issue_q.size() != 0) check("start_xy", {mul_x, mul_y}, issue_q.pop_front());
                start_cnt++;
                last_start_cyc = cycle;
            end
            if (prev_valid && !prev_acc) begin
                check("hold_valid", {31'b0, out_valid}, 32'd1);
                check("hold_z", out_z, prev_z);
            end
            if (out_valid && !prev_valid) last_lat = cycle - last_start_cyc;
            if (out_valid && out_ready) begin
                check("result_expected", {31'b0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) check("out_z", out_z, exp_q.pop_front());
                result_cnt++;
                last_z = out_z;
            end
            prev_start = mul_start;
            prev_valid = out_valid;
            prev_acc   = out_valid && out_ready;
            prev_z     = out_z;
        end else begin
            prev_start = 1'b0;
            prev_valid = 1'b0;
            prev_acc   = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    logic rand_ready = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic push_op(input logic [15:0] x, input logic [15:0] y, input logic drop);
        logic ok = 1'b0;
        tick();
        in_x     = x;
        in_y     = y;
        in_valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
        in_valid = 1'b0;
        check("push_accepted", {31'b0, ok}, 32'd1);
        if (ok) begin
            issue_q.push_back({x, y});
            if (!drop) exp_q.push_back(model_result(x, y));
        end
    endtask

    task automatic wait_drain(input int bound);
        for (int i = 0; i < bound; i++) begin
            tick();
            @(negedge clk);
            if (exp_q.size() == 0 && issue_q.size() == 0 && !out_valid) break;
        end
        check("drain_left", exp_q.size(), 32'd0);
    endtask

    task automatic wait_start(input int s0);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (start_cnt != s0) break;
        end
        check("start_seen", {31'b0, start_cnt != s0}, 32'd1);
    endtask

    // ---------------- test sequence ----------------
    int s0, r0;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("rst_mul_start", {31'b0, mul_start}, 32'd0);
        check("rst_err", {31'b0, err}, 32'd0);
        check("rst_out_z", out_z, 32'd0);
        check("rst_mul_xy", {mul_x, mul_y}, 32'd0);
        rst_n = 1'b1;

        // Single op, busy 16 cycles
        lat_sel = 16;
        seen_not_ready = 1'b0;
        s0 = start_cnt;
        push_op(16'd3, 16'd5, 1'b0);
        wait_drain(200);
        check("single_starts", start_cnt - s0, 32'd1);
        check("single_last_z", last_z, 32'd15);
        check("single_in_ready_stayed", {31'b0, seen_not_ready}, 32'd0);

        // Busy never rises: capture after the arm timeout
        comb_mode = 1'b1;
        push_op(16'd7, 16'd6, 1'b0);
        wait_drain(200);
        check("arm_timeout_lat", last_lat, ARM_CYC + 2);
        check("arm_timeout_z", last_z, 32'd42);
        comb_mode = 1'b0;

        // Back-pressure: five pairs with the result port stalled
        lat_sel = 3;
        out_ready = 1'b0;
        r0 = result_cnt;
        for (int i = 1; i <= 5; i++) push_op(16'(i * 100), 16'(i + 7), 1'b0);
        @(negedge clk);
        check("bp_full", {31'b0, in_ready}, 32'd0);
        repeat (10) @(negedge clk);
        check("bp_valid_held", {31'b0, out_valid}, 32'd1);
        check("bp_still_full", {31'b0, in_ready}, 32'd0);
        tick();
        out_ready = 1'b1;
        wait_drain(500);
        check("bp_results", result_cnt - r0, 32'd5);

        // Stuck busy: watchdog aborts, op dropped, next op still works
        stuck_mode = 1'b1;
        s0 = start_cnt;
        r0 = result_cnt;
        push_op(16'd11, 16'd13, 1'b1);
        wait_start(s0);
        repeat (35) @(negedge clk);
        check("wd_not_early", {31'b0, err}, 32'd0);
        repeat (10) @(negedge clk);
        check("wd_err", {31'b0, err}, 32'd1);
        check("wd_no_result", result_cnt - r0, 32'd0);
        stuck_mode = 1'b0;
        lat_sel = 5;
        push_op(16'd9, 16'd9, 1'b0);
        wait_drain(300);
        check("wd_recover_z", last_z, model_result_peek());
        check("wd_err_sticky", {31'b0, err}, 32'd1);

        // Randomised traffic with random latency and random out_ready
        lat_sel = 0;
        rand_ready = 1'b1;
        for (int n = 0; n < 30; n++) begin
            logic [15:0] rx, ry;
            rx = 16'($urandom);
            ry = 16'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                rx = '0;
                ry = '0;
            end
            push_op(rx, ry, 1'b0);
            repeat ($urandom_range(0, 3)) tick();
        end
        wait_drain(3000);
        rand_ready = 1'b0;
        out_ready = 1'b1;

        // Reset in the middle of RUN
        lat_sel = 30;
        s0 = start_cnt;
        push_op(16'd5, 16'd5, 1'b1);
        push_op(16'd6, 16'd6, 1'b1);
        wait_start(s0);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("mid_rst_err", {31'b0, err}, 32'd0);
        check("mid_rst_start", {31'b0, mul_start}, 32'd0);
        issue_q.delete();
        exp_q.delete();
        acc_m = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        s0 = start_cnt;
        repeat (20) @(negedge clk);
        check("mid_rst_no_start", start_cnt - s0, 32'd0);
        check("mid_rst_empty", {31'b0, in_ready}, 32'd1);

        // Accumulator sequence (plain products when the feature is off)
        lat_sel = 4;
        push_op(16'd2, 16'd3, 1'b0);
        push_op(16'd4, 16'd5, 1'b0);
        push_op(16'd0, 16'd0, 1'b0);
        push_op(16'd1, 16'd1, 1'b0);
        wait_drain(500);
        check("acc_last", last_z, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Expected value of the most recently modelled result, without advancing the model.
    function automatic logic [31:0] model_result_peek();
`ifdef MUL_DISPATCH_ACC_EN
        return acc_m;
`else
        return 32'd81;
`endif
    endfunction

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
